// File: rtl/clk_gen_ctrl.sv
// Bring-up sequencer and pattern supervisor for the Rx divided-clock generator
// (clk10/clk20/clk40): resets, warms up, aligns a 16-phase frame, then checks it.
module clk_gen_ctrl #(
    parameter int WARMUP_CYC = 16,
    parameter int ALIGN_TMO  = 32,
    parameter int MAX_RETRY  = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clk10,
    input  logic       i_clk20,
    input  logic       i_clk40,
    output logic       o_gen_rst,
    output logic       o_gen_enb,
    output logic       o_ready,
    output logic       o_fault,
    output logic [3:0] o_phase,
    output logic       o_frame_stb,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RSTGEN = 3'd1,
        ST_WARMUP = 3'd2,
        ST_ALIGN  = 3'd3,
        ST_RUN    = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    localparam int CNT_MAX = (WARMUP_CYC > ALIGN_TMO) ? WARMUP_CYC : ALIGN_TMO;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 2);

    // Expected {clk10,clk20,clk40} per phase; phase 0 sits in the low bits.
    localparam logic [47:0] PATTERN = {
        3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b010, 3'b110, 3'b110,
        3'b001, 3'b001, 3'b101, 3'b101, 3'b011, 3'b011, 3'b111, 3'b111
    };

    function automatic logic [2:0] expected_trip(input logic [3:0] p);
        return PATTERN[3*int'(p) +: 3];
    endfunction

    state_t          r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [RW-1:0]   r_retry, w_retry;
    logic [3:0]      r_phase, w_phase;
    logic            r_fault, w_fault;
    logic            r_ready, w_ready;
    logic            r_gen_rst, w_gen_rst;
    logic            r_gen_enb, w_gen_enb;
    logic            r_frame_stb, w_frame_stb;
    logic            r_prev_zero;
    logic            w_fault_evt;
    logic [2:0]      w_trip;
    logic [3:0]      w_phase_inc;

    assign w_trip      = {i_clk10, i_clk20, i_clk40};
    assign w_phase_inc = r_phase + 4'd1;

    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_retry     = r_retry;
        w_phase     = r_phase;
        w_fault     = r_fault;
        w_frame_stb = 1'b0;
        w_fault_evt = 1'b0;

        unique case (r_state)
            ST_OFF: begin
                if (i_start) begin
                    w_state = ST_WARMUP;
                    w_cnt   = '0;
                    w_retry = '0;
                    w_fault = 1'b0;
                end
            end
            ST_RSTGEN: begin
                if (r_cnt == CW'(1)) begin
                    w_state = ST_WARMUP;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            ST_WARMUP: begin
                if (r_cnt == CW'(WARMUP_CYC - 1)) begin
                    w_state = ST_ALIGN;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            ST_ALIGN: begin
                // The 000 -> 111 edge marks the frame wrap; this sample is phase 0.
                if (r_prev_zero && (w_trip == 3'b111)) begin
                    w_state = ST_RUN;
                    w_phase = 4'd0;
                    w_cnt   = '0;
                end else if (r_cnt == CW'(ALIGN_TMO - 1)) begin
                    w_fault_evt = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            ST_RUN: begin
                if (w_trip != expected_trip(w_phase_inc)) begin
                    w_fault_evt = 1'b1;
                end else begin
                    w_phase     = w_phase_inc;
                    w_frame_stb = (w_phase_inc == 4'd15);
                    if (w_phase_inc == 4'd0)
                        w_fault = 1'b0;
                end
            end
            ST_FAULT: begin
                if (i_start) begin
                    w_state = ST_RSTGEN;
                    w_cnt   = '0;
                    w_retry = '0;
                    w_fault = 1'b0;
                end
            end
            default: w_state = ST_OFF;
        endcase

        if (w_fault_evt) begin
            w_fault = 1'b1;
            w_cnt   = '0;
            w_phase = 4'd0;
            if (r_retry < RW'(MAX_RETRY)) begin
                w_retry = r_retry + RW'(1);
                w_state = ST_RSTGEN;
            end else begin
                w_state = ST_FAULT;
            end
        end

        if (i_stop) begin
            w_state     = ST_OFF;
            w_fault     = 1'b0;
            w_cnt       = '0;
            w_phase     = 4'd0;
            w_frame_stb = 1'b0;
        end

        // Generator controls and ready follow the state being entered, so they are registered.
        w_gen_enb = (w_state == ST_WARMUP) || (w_state == ST_ALIGN) || (w_state == ST_RUN);
        w_gen_rst = !w_gen_enb;
        w_ready   = (w_state == ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_OFF;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_phase     <= 4'd0;
            r_fault     <= 1'b0;
            r_ready     <= 1'b0;
            r_gen_rst   <= 1'b1;
            r_gen_enb   <= 1'b0;
            r_frame_stb <= 1'b0;
            r_prev_zero <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_retry     <= w_retry;
            r_phase     <= w_phase;
            r_fault     <= w_fault;
            r_ready     <= w_ready;
            r_gen_rst   <= w_gen_rst;
            r_gen_enb   <= w_gen_enb;
            r_frame_stb <= w_frame_stb;
            r_prev_zero <= (w_trip == 3'b000);
        end
    end

    assign o_state     = r_state;
    assign o_gen_rst   = r_gen_rst;
    assign o_gen_enb   = r_gen_enb;
    assign o_ready     = r_ready;
    assign o_fault     = r_fault;
    assign o_phase     = r_phase;
    assign o_frame_stb = r_frame_stb;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl with a behavioural divided-clock generator attached.
module tb_clk_gen_ctrl;

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_RSTGEN = 3'd1;
    localparam logic [2:0] S_WARMUP = 3'd2;
    localparam logic [2:0] S_ALIGN  = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic       clk10, clk20, clk40;
    logic       gen_rst, gen_enb, ready, fault, frame_stb;
    logic [3:0] phase;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    // Generator model: phase counter held in reset by gen_rst, runs while gen_enb.
    logic [2:0] tbl [16] = '{3'b111, 3'b111, 3'b011, 3'b011, 3'b101, 3'b101, 3'b001, 3'b001,
                             3'b110, 3'b110, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000};
    logic [3:0] g = 4'd0;
    logic       f20_low  = 1'b0;
    logic       f40_high = 1'b0;

    always @(posedge clk) begin
        if (gen_rst)      g <= 4'd0;
        else if (gen_enb) g <= g + 4'd1;
    end

    logic [2:0] cur;
    assign cur   = tbl[g];
    assign clk10 = cur[2];
    assign clk20 = f20_low  ? 1'b0 : cur[1];
    assign clk40 = f40_high ? 1'b1 : cur[0];

    always #5 clk = ~clk;

    clk_gen_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_stop      (stop),
        .i_clk10     (clk10),
        .i_clk20     (clk20),
        .i_clk40     (clk40),
        .o_gen_rst   (gen_rst),
        .o_gen_enb   (gen_enb),
        .o_ready     (ready),
        .o_fault     (fault),
        .o_phase     (phase),
        .o_frame_stb (frame_stb),
        .o_state     (state)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int max_cyc, input string tag);
        int n = 0;
        while (state !== target && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, 8'(state), 8'(target));
    endtask

    task automatic wait_phase(input logic [3:0] target, input int max_cyc, input string tag);
        int n = 0;
        while (phase !== target && n < max_cyc) begin
            step();
            n++;
        end
        check(tag, 8'(phase), 8'(target));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [3:0] exp_ph;

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        step(); step();
        check("rst_state",   8'(state),     8'(S_OFF));
        check("rst_gen_rst", 8'(gen_rst),   8'd1);
        check("rst_gen_enb", 8'(gen_enb),   8'd0);
        check("rst_ready",   8'(ready),     8'd0);
        check("rst_fault",   8'(fault),     8'd0);
        check("rst_phase",   8'(phase),     8'd0);
        check("rst_stb",     8'(frame_stb), 8'd0);
        check("rst_retry",   8'(dut.r_retry), 8'd0);
        rst = 1'b0;
        step();
        check("idle_off", 8'(state), 8'(S_OFF));

        // Nominal bring-up
        pulse_start();
        check("up_warmup",  8'(state),   8'(S_WARMUP));
        check("up_gen_enb", 8'(gen_enb), 8'd1);
        check("up_gen_rst", 8'(gen_rst), 8'd0);
        for (int i = 0; i < 15; i++) step();
        check("warmup_last", 8'(state), 8'(S_WARMUP));
        step();
        check("align_enter", 8'(state), 8'(S_ALIGN));
        wait_state(S_RUN, 16, "align_lock");
        check("lock_ready", 8'(ready), 8'd1);
        check("lock_phase", 8'(phase), 8'd0);
        exp_ph = 4'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_ph = exp_ph + 4'd1;
            check("run_phase", 8'(phase),     8'(exp_ph));
            check("run_stb",   8'(frame_stb), 8'(exp_ph == 4'd15));
            check("run_ready", 8'(ready),     8'd1);
        end
        check("run_fault", 8'(fault), 8'd0);

        // Stuck clk20 at phase 2
        wait_phase(4'd1, 20, "stuck_pre");
        f20_low = 1'b1;
        step();
        f20_low = 1'b0;
        check("stuck_ready", 8'(ready),       8'd0);
        check("stuck_fault", 8'(fault),       8'd1);
        check("stuck_state", 8'(state),       8'(S_RSTGEN));
        check("stuck_retry", 8'(dut.r_retry), 8'd1);
        check("stuck_grst",  8'(gen_rst),     8'd1);
        step();
        check("rstgen_2nd", 8'(state), 8'(S_RSTGEN));
        step();
        check("rstgen_done", 8'(state), 8'(S_WARMUP));
        wait_state(S_RUN, 60, "reacquire");
        check("reacq_fault", 8'(fault), 8'd1);
        wait_phase(4'd15, 20, "reacq_p15");
        check("p15_fault", 8'(fault), 8'd1);
        step();
        check("wrap_phase", 8'(phase), 8'd0);
        check("wrap_fault", 8'(fault), 8'd0);

        // Start while running is ignored
        pulse_start();
        check("srun_state", 8'(state), 8'(S_RUN));
        check("srun_phase", 8'(phase), 8'd1);
        check("srun_ready", 8'(ready), 8'd1);

        // Stop during RUN
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_state", 8'(state),   8'(S_OFF));
        check("stop_ready", 8'(ready),   8'd0);
        check("stop_enb",   8'(gen_enb), 8'd0);
        check("stop_grst",  8'(gen_rst), 8'd1);

        // start+stop together in WARMUP
        pulse_start();
        check("ss_warm", 8'(state), 8'(S_WARMUP));
        step(); step(); step();
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        check("ss_off", 8'(state), 8'(S_OFF));

        // Async reset mid-WARMUP, between clock edges
        pulse_start();
        step(); step(); step();
        check("ar_warm", 8'(state), 8'(S_WARMUP));
        #2 rst = 1'b1;
        #1;
        check("ar_state", 8'(state),   8'(S_OFF));
        check("ar_grst",  8'(gen_rst), 8'd1);
        check("ar_enb",   8'(gen_enb), 8'd0);
        step();
        rst = 1'b0;
        step(); step(); step();
        check("ar_stay_off", 8'(state), 8'(S_OFF));

        // Permanent fault: clk40 stuck high, alignment never found
        f40_high = 1'b1;
        pulse_start();
        wait_state(S_FAULT, 400, "perm_fault");
        check("perm_retry", 8'(dut.r_retry), 8'd3);
        check("perm_grst",  8'(gen_rst),     8'd1);
        check("perm_enb",   8'(gen_enb),     8'd0);
        check("perm_flt",   8'(fault),       8'd1);
        check("perm_ready", 8'(ready),       8'd0);
        step();
        check("perm_hold", 8'(state), 8'(S_FAULT));
        pulse_start();
        check("restart_state", 8'(state),       8'(S_RSTGEN));
        check("restart_retry", 8'(dut.r_retry), 8'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        f40_high = 1'b0;
        check("final_off", 8'(state), 8'(S_OFF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
